// File: rtl/alarma_ctrl.sv
// Alarm controller fed by the alarm-equation output: arming, trigger debounce,
// entry delay, timed siren and saturating event count. Define ALARMA_LATCH_EN to latch the siren.
module alarma_ctrl #(
   parameter int DEB_LEN   = 3,
   parameter int ENTRY_DLY = 8,
   parameter int SIREN_LEN = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       arm,
   input  logic       disarm,
   input  logic       trig,
   output logic [1:0] state,
   output logic       armed,
   output logic       pending,
   output logic       siren,
   output logic [3:0] event_cnt
);

   localparam int DEB_W = (DEB_LEN   > 1) ? $clog2(DEB_LEN)   : 1;
   localparam int DLY_W = (ENTRY_DLY > 1) ? $clog2(ENTRY_DLY) : 1;

   // Debounce fires on the edge where the counter already holds DEB_LEN-1 and trig is
   // still high, so the counter never has to represent DEB_LEN itself.
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_LEN - 1);
   localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(ENTRY_DLY - 1);

   typedef enum logic [1:0] {
      S_DISARMED = 2'd0,
      S_ARMED    = 2'd1,
      S_ENTRY    = 2'd2,
      S_ALARM    = 2'd3
   } state_t;

   state_t           cur_q, nxt;
   logic [DEB_W-1:0] deb_q, deb_nxt;
   logic [DLY_W-1:0] dly_q, dly_nxt;
   logic [3:0]       evt_nxt;

`ifndef ALARMA_LATCH_EN
   localparam int SIR_W = (SIREN_LEN > 1) ? $clog2(SIREN_LEN) : 1;
   localparam logic [SIR_W-1:0] SIR_LAST = SIR_W'(SIREN_LEN - 1);
   logic [SIR_W-1:0] sir_q, sir_nxt;
`endif

   always_comb begin
      nxt     = cur_q;
      deb_nxt = deb_q;
      dly_nxt = dly_q;
      evt_nxt = event_cnt;
`ifndef ALARMA_LATCH_EN
      sir_nxt = sir_q;
`endif
      unique case (cur_q)
         S_DISARMED: begin
            deb_nxt = '0;
            if (arm && !disarm) nxt = S_ARMED;
         end
         S_ARMED: begin
            if (disarm) begin
               nxt     = S_DISARMED;
               deb_nxt = '0;
            end else if (!trig) begin
               deb_nxt = '0;
            end else if (deb_q == DEB_LAST) begin
               nxt     = S_ENTRY;
               deb_nxt = '0;
               dly_nxt = DLY_LAST;
            end else begin
               deb_nxt = deb_q + DEB_W'(1);
            end
         end
         S_ENTRY: begin
            if (disarm) begin
               nxt = S_DISARMED;
            end else if (dly_q == '0) begin
               nxt = S_ALARM;
               if (event_cnt != 4'd15) evt_nxt = event_cnt + 4'd1;
`ifndef ALARMA_LATCH_EN
               sir_nxt = SIR_LAST;
`endif
            end else begin
               dly_nxt = dly_q - DLY_W'(1);
            end
         end
         S_ALARM: begin
            if (disarm) begin
               nxt = S_DISARMED;
            end
`ifndef ALARMA_LATCH_EN
            else if (sir_q == '0) begin
               nxt     = S_ARMED;
               deb_nxt = '0;
            end else begin
               sir_nxt = sir_q - SIR_W'(1);
            end
`endif
         end
      endcase
   end

   // Output flags decode the next state so they switch on the same edge as state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_q     <= S_DISARMED;
         deb_q     <= '0;
         dly_q     <= '0;
`ifndef ALARMA_LATCH_EN
         sir_q     <= '0;
`endif
         event_cnt <= '0;
         armed     <= 1'b0;
         pending   <= 1'b0;
         siren     <= 1'b0;
      end else begin
         cur_q     <= nxt;
         deb_q     <= deb_nxt;
         dly_q     <= dly_nxt;
`ifndef ALARMA_LATCH_EN
         sir_q     <= sir_nxt;
`endif
         event_cnt <= evt_nxt;
         armed     <= (nxt != S_DISARMED);
         pending   <= (nxt == S_ENTRY);
         siren     <= (nxt == S_ALARM);
      end
   end

   assign state = cur_q;

endmodule
